normalize_pipe: RTL and testbench

NORMALIZE_PIPE -- requirements
Module: normalize_pipe

---
 rtl/normalize_pipe.sv | 146 ++++++++++++++
 tb/tb_normalize_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_pipe.sv
// Two-stage floating-point normalizer: S1 captures the operand with its leading-zero count,
// S2 shifts and adjusts the exponent. Define NORM_UFLOW_CNT_EN to add the uflow_cnt output.
module normalize_pipe #(
  parameter int MW = 11,
  parameter int EW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign_in,
  input  logic [EW-1:0] exp_in,
  input  logic [MW-1:0] mant_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign_out,
  output logic [EW-1:0] exp_out,
  output logic [MW-1:0] mant_out,
  output logic          zero_out,
  output logic          uflow_out
`ifdef NORM_UFLOW_CNT_EN
  ,
  output logic [15:0]   uflow_cnt
`endif
);

  localparam int LZW = $clog2(MW + 1);
  localparam int CW  = ((EW > LZW) ? EW : LZW) + 1;

  logic           s1_valid_q, s1_valid_d;
  logic           s1_sign_q;
  logic [EW-1:0]  s1_exp_q;
  logic [MW-1:0]  s1_mant_q;
  logic [LZW-1:0] s1_lz_q;

  logic           s2_valid_q, s2_valid_d;
  logic           s2_sign_q;
  logic [EW-1:0]  s2_exp_q, s2_exp_d;
  logic [MW-1:0]  s2_mant_q, s2_mant_d;
  logic           s2_zero_q, s2_zero_d;
  logic           s2_uflow_q, s2_uflow_d;

  logic           s2_ready, in_fire, s1_adv, out_fire;
  logic [LZW-1:0] lz_d;
  logic [CW-1:0]  exp_ext, lz_ext, shamt;

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign out_fire = s2_valid_q && out_ready;

  assign s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
  assign s2_valid_d = s1_adv || (s2_valid_q && !out_ready);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz_d = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (mant_in[i]) lz_d = LZW'(MW - 1 - i);
    end
  end

  always_comb begin
    exp_ext    = CW'(s1_exp_q);
    lz_ext     = CW'(s1_lz_q);
    shamt      = (exp_ext > lz_ext) ? lz_ext : exp_ext;
    s2_mant_d  = '0;
    s2_exp_d   = '0;
    s2_zero_d  = 1'b0;
    s2_uflow_d = 1'b0;
    if (s1_mant_q == '0) begin
      s2_zero_d = 1'b1;
    end else if (exp_ext > lz_ext) begin
      s2_mant_d = s1_mant_q << shamt;
      s2_exp_d  = EW'(exp_ext - lz_ext);
    end else begin
      // Exponent would go negative: stop shifting at exponent 0 (denormal).
      s2_mant_d  = s1_mant_q << shamt;
      s2_uflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_lz_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_sign_q <= sign_in;
        s1_exp_q  <= exp_in;
        s1_mant_q <= mant_in;
        s1_lz_q   <= lz_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        s2_sign_q  <= s1_sign_q;
        s2_exp_q   <= s2_exp_d;
        s2_mant_q  <= s2_mant_d;
        s2_zero_q  <= s2_zero_d;
        s2_uflow_q <= s2_uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_out  = s2_sign_q;
  assign exp_out   = s2_exp_q;
  assign mant_out  = s2_mant_q;
  assign zero_out  = s2_zero_q;
  assign uflow_out = s2_uflow_q;

`ifdef NORM_UFLOW_CNT_EN
  logic [15:0] uflow_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt_q <= '0;
    end else if (out_fire && s2_uflow_q && (uflow_cnt_q != 16'hFFFF)) begin
      uflow_cnt_q <= uflow_cnt_q + 16'd1;
    end
  end

  assign uflow_cnt = uflow_cnt_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_normalize_pipe.sv
// Self-checking bench for normalize_pipe: directed vector table, stall/reset sequences,
// and randomized traffic scored against a shift-until-normalized reference model.
module tb_normalize_pipe;
  localparam int MW = 11;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, sign_in;
  logic [EW-1:0] exp_in;
  logic [MW-1:0] mant_in;
  logic          out_valid, out_ready, sign_out, zero_out, uflow_out;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] mant_out;
`ifdef NORM_UFLOW_CNT_EN
  logic [15:0]   uflow_cnt;
`endif

  normalize_pipe #(.MW(MW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .zero_out(zero_out), .uflow_out(uflow_out)
`ifdef NORM_UFLOW_CNT_EN
    , .uflow_cnt(uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic          zero;
    logic          uflow;
  } res_t;

  typedef struct {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          es;
    logic [EW-1:0] ee;
    logic [MW-1:0] em;
    logic          ez;
    logic          eu;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  int   pops   = 0;
  int   ucnt_model = 0;
  logic last_in_fire, last_in_ready;
  res_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: double the mantissa until its top bit is set or the exponent reaches 0.
  function automatic res_t model(logic s, logic [EW-1:0] e, logic [MW-1:0] m);
    res_t r;
    int   mv = int'(m);
    int   ev = int'(e);
    r.sign = s;
    if (mv == 0) begin
      r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0;
    end else begin
      while (ev > 0 && mv < (1 << (MW - 1))) begin
        mv = mv * 2;
        ev = ev - 1;
      end
      r.mant = mv[MW-1:0]; r.exp = ev[EW-1:0]; r.zero = 1'b0; r.uflow = (ev == 0);
    end
    return r;
  endfunction

  task automatic cycle();
    res_t e;
    @(negedge clk);
`ifdef NORM_UFLOW_CNT_EN
    chk("uflow_cnt", 32'(uflow_cnt), 32'(ucnt_model));
`endif
    last_in_ready = in_ready;
    last_in_fire  = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("sb_sign", 32'(sign_out), 32'(e.sign));
        chk("sb_exp", 32'(exp_out), 32'(e.exp));
        chk("sb_mant", 32'(mant_out), 32'(e.mant));
        chk("sb_zero", 32'(zero_out), 32'(e.zero));
        chk("sb_uflow", 32'(uflow_out), 32'(e.uflow));
        if (e.uflow && ucnt_model != 16'hFFFF) ucnt_model++;
      end
    end
    if (last_in_fire) sb.push_back(model(sign_in, exp_in, mant_in));
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[8];
  logic [MW-1:0] seq_m[4];

  initial begin
    vecs[0] = '{1'b1, 5'd10, 11'b00000101100, 1'b1, 5'd5,  11'b10110000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'd3,  11'b00000000001, 1'b0, 5'd0,  11'b00000001000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd17, 11'b00000000000, 1'b1, 5'd0,  11'b00000000000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 5'd15, 11'b10000000000, 1'b0, 5'd15, 11'b10000000000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  11'b10000000000, 1'b1, 5'd0,  11'b10000000000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd31, 11'b00000000001, 1'b0, 5'd21, 11'b10000000000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd10, 11'b00000000001, 1'b1, 5'd0,  11'b10000000000, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 5'd5,  11'b01111111111, 1'b0, 5'd4,  11'b11111111110, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; exp_in = '0; mant_in = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mant", 32'(mant_out), 32'd0);
    chk("rst_exp", 32'(exp_out), 32'd0);
    chk("rst_zero", 32'(zero_out), 32'd0);
    chk("rst_uflow", 32'(uflow_out), 32'd0);
`ifdef NORM_UFLOW_CNT_EN
    chk("rst_uflow_cnt", 32'(uflow_cnt), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, one at a time, with exact 2-cycle latency checks.
    for (int v = 0; v < 8; v++) begin
      sign_in = vecs[v].s; exp_in = vecs[v].e; mant_in = vecs[v].m; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_lat1_valid", v), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_sign", v), 32'(sign_out), 32'(vecs[v].es));
      chk($sformatf("v%0d_exp", v), 32'(exp_out), 32'(vecs[v].ee));
      chk($sformatf("v%0d_mant", v), 32'(mant_out), 32'(vecs[v].em));
      chk($sformatf("v%0d_zero", v), 32'(zero_out), 32'(vecs[v].ez));
      chk($sformatf("v%0d_uflow", v), 32'(uflow_out), 32'(vecs[v].eu));
      if (vecs[v].eu) ucnt_model++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pipe_empty", 32'(out_valid), 32'd0);
`ifdef NORM_UFLOW_CNT_EN
    chk("uflow_cnt_table", 32'(uflow_cnt), 32'(ucnt_model));
`endif
    @(posedge clk); #1;

    // Four back-to-back operands against a 3-cycle downstream stall.
    seq_m[0] = 11'b00000000111; seq_m[1] = 11'b00100000000;
    seq_m[2] = 11'b00000000000; seq_m[3] = 11'b00000010001;
    begin
      int k = 0;
      int pops0 = pops;
      for (int c = 0; c < 20 && k < 4; c++) begin
        in_valid = 1'b1; sign_in = k[0]; exp_in = 5'(k + 4); mant_in = seq_m[k];
        out_ready = (c >= 3);
        cycle();
        if (c == 2) begin
          chk("stall_in_ready", 32'(last_in_ready), 32'd0);
          chk("stall_accepted", 32'(k), 32'd2);
        end
        if (last_in_fire) k++;
      end
      chk("stall_all_accepted", 32'(k), 32'd4);
      drain(20);
      chk("stall_all_out", 32'(pops - pops0), 32'd4);
    end

    // Reset with two operands in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    sign_in = 1'b1; exp_in = 5'd9; mant_in = 11'b00000011000;
    cycle(); cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mant", 32'(mant_out), 32'd0);
    chk("midrst_exp", 32'(exp_out), 32'd0);
    chk("midrst_sign", 32'(sign_out), 32'd0);
    sb.delete();
    ucnt_model = 0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      sign_in   = 1'($urandom);
      exp_in    = EW'($urandom);
      case ($urandom % 4)
        0: mant_in = '0;
        1: mant_in = MW'(1) << ($urandom % MW);
        2: mant_in = MW'($urandom) >> ($urandom % MW);
        default: mant_in = MW'($urandom);
      endcase
      cycle();
    end
    drain(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
